// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RISC-V
// opcode/funct3 encodings, fault causes and small decode helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_DONE
  } LsuState;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] CAUSE_NONE       = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;

  // Doubleword and unsigned-word accesses only exist on a 64-bit datapath.
  function automatic logic funct3_legal(input logic is_load, input logic [2:0] funct3,
                                        input logic wide);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
        F3_D, F3_WU:                    ok = wide;
        default:                        ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_H, F3_W: ok = 1'b1;
        F3_D:             ok = wide;
        default:          ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [2:0] size_mask(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data placement and load lane extraction
// with sign or zero extension, selected by funct3 and the byte offset.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_data,
  output logic [NB-1:0]   strb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_value
);

  logic [NB-1:0]   size_bytes;
  logic [XLEN-1:0] data_mask;
  logic [XLEN-1:0] shifted;
  logic [OFFW+2:0] bit_shift;

  assign bit_shift = {offset, 3'b000};

  always_comb begin
    size_bytes = '0;
    data_mask  = '0;
    for (int i = 0; i < NB; i++) begin
      size_bytes[i]      = (i < (1 << funct3[1:0]));
      data_mask[8*i +: 8] = {8{size_bytes[i]}};
    end
    strb    = size_bytes << offset;
    wdata   = (store_data & data_mask) << bit_shift;
    shifted = load_data >> bit_shift;
    // funct3[2] marks the unsigned load variants.
    case (funct3[1:0])
      2'd0:    load_value = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'(signed'(shifted[7:0]));
      2'd1:    load_value = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'(signed'(shifted[15:0]));
      2'd2:    load_value = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'(signed'(shifted[31:0]));
      default: load_value = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RISC-V load/store execution unit: decodes one LOAD/STORE, drives a
// byte-strobed req/ready memory port and returns load data for write-back.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_SELECT_LEN = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [31:0]               instruction,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  output logic                      busy,
  output logic                      done,
  output logic                      fault,
  output logic [1:0]                fault_cause,
  output logic                      rd_we,
  output logic [REG_SELECT_LEN-1:0] rd_addr,
  output logic [XLEN-1:0]           rd_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  output logic [XLEN/8-1:0]         mem_strb,
  input  logic                      mem_ready,
  input  logic [XLEN-1:0]           mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic WIDE = (XLEN == 64);

  LsuState state, state_n;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load_op, is_store_op, illegal, misaligned;
  logic [11:0]     imm12;
  logic [XLEN-1:0] eff_addr;
  logic [OFFW-1:0] byte_off;
  logic [NB-1:0]   req_strb;
  logic [XLEN-1:0] req_wdata, resp_value;

  logic [2:0]                funct3_q, funct3_n;
  logic [OFFW-1:0]           off_q, off_n;
  logic [REG_SELECT_LEN-1:0] rd_q, rd_n;
  logic                      load_q, load_n;
  logic [XLEN-1:0]           rdata_q, rdata_n;

  logic                      busy_n, done_n, fault_n, rd_we_n, mem_req_n, mem_we_n;
  logic [1:0]                cause_n;
  logic [REG_SELECT_LEN-1:0] rd_addr_n;
  logic [XLEN-1:0]           rd_data_n, mem_addr_n, mem_wdata_n;
  logic [NB-1:0]             mem_strb_n;

  logic [4:0]      unused_rs1_field;
  logic [XLEN-1:0] unused_req_value, unused_resp_wdata;
  logic [NB-1:0]   unused_resp_strb;

  assign unused_rs1_field = instruction[19:15];

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign is_load_op  = (opcode == OPCODE_LOAD);
  assign is_store_op = (opcode == OPCODE_STORE);
  assign imm12       = is_store_op ? {instruction[31:25], instruction[11:7]} : instruction[31:20];
  assign eff_addr    = rs1_data + XLEN'(signed'(imm12));
  assign byte_off    = eff_addr[OFFW-1:0];
  assign illegal     = !(is_load_op || is_store_op) || !funct3_legal(is_load_op, funct3, WIDE);
  assign misaligned  = (3'(byte_off) & size_mask(funct3[1:0])) != 3'b000;

  lsu_align #(.XLEN(XLEN)) u_req_align (
    .funct3     (funct3),
    .offset     (byte_off),
    .store_data (rs2_data),
    .load_data  ('0),
    .strb       (req_strb),
    .wdata      (req_wdata),
    .load_value (unused_req_value)
  );

  lsu_align #(.XLEN(XLEN)) u_resp_align (
    .funct3     (funct3_q),
    .offset     (off_q),
    .store_data ('0),
    .load_data  (rdata_q),
    .strb       (unused_resp_strb),
    .wdata      (unused_resp_wdata),
    .load_value (resp_value)
  );

  // Every output is computed here one cycle ahead and registered below.
  always_comb begin
    state_n     = state;
    funct3_n    = funct3_q;
    off_n       = off_q;
    rd_n        = rd_q;
    load_n      = load_q;
    rdata_n     = rdata_q;
    done_n      = done;
    fault_n     = fault;
    cause_n     = fault_cause;
    rd_we_n     = rd_we;
    rd_addr_n   = rd_addr;
    rd_data_n   = rd_data;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_strb_n  = mem_strb;
    case (state)
      LSU_IDLE: begin
        if (start) begin
          funct3_n = funct3;
          off_n    = byte_off;
          rd_n     = REG_SELECT_LEN'(instruction[11:7]);
          load_n   = is_load_op;
          if (illegal || misaligned) begin
            state_n = LSU_DONE;
            done_n  = 1'b1;
            fault_n = 1'b1;
            cause_n = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
          end else begin
            state_n     = LSU_REQ;
            mem_req_n   = 1'b1;
            mem_we_n    = is_store_op;
            mem_addr_n  = eff_addr & ~XLEN'(NB - 1);
            mem_strb_n  = req_strb;
            mem_wdata_n = req_wdata;
          end
        end
      end
      LSU_REQ: begin
        if (mem_ready) begin
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          mem_addr_n  = '0;
          mem_strb_n  = '0;
          mem_wdata_n = '0;
          if (load_q) begin
            rdata_n = mem_rdata;
            state_n = LSU_RESP;
          end else begin
            state_n = LSU_DONE;
            done_n  = 1'b1;
          end
        end
      end
      LSU_RESP: begin
        state_n   = LSU_DONE;
        done_n    = 1'b1;
        rd_we_n   = (rd_q != '0);
        rd_addr_n = rd_q;
        rd_data_n = resp_value;
      end
      LSU_DONE: begin
        state_n   = LSU_IDLE;
        done_n    = 1'b0;
        fault_n   = 1'b0;
        cause_n   = CAUSE_NONE;
        rd_we_n   = 1'b0;
        rd_addr_n = '0;
        rd_data_n = '0;
      end
      default: state_n = LSU_IDLE;
    endcase
    busy_n = (state_n != LSU_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LSU_IDLE;
      funct3_q    <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      load_q      <= 1'b0;
      rdata_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      rd_we       <= 1'b0;
      rd_addr     <= '0;
      rd_data     <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_strb    <= '0;
    end else begin
      state       <= state_n;
      funct3_q    <= funct3_n;
      off_q       <= off_n;
      rd_q        <= rd_n;
      load_q      <= load_n;
      rdata_q     <= rdata_n;
      busy        <= busy_n;
      done        <= done_n;
      fault       <= fault_n;
      fault_cause <= cause_n;
      rd_we       <= rd_we_n;
      rd_addr     <= rd_addr_n;
      rd_data     <= rd_data_n;
      mem_req     <= mem_req_n;
      mem_we      <= mem_we_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      mem_strb    <= mem_strb_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: a 32-bit and a 64-bit LSU driven with directed and
// random transactions, checked every cycle against a per-cycle expectation queue.
module tb_load_store_unit;

  typedef struct packed {
    bit        busy, done, fault;
    bit [1:0]  cause;
    bit        rd_we;
    bit [4:0]  rd_addr;
    bit [63:0] rd_data;
    bit        mem_req, mem_we;
    bit [63:0] mem_addr, mem_wdata;
    bit [7:0]  mem_strb;
  } obs_t;

  typedef struct packed {
    bit        fault;
    bit [1:0]  cause;
    bit        is_load, rd_we;
    bit [4:0]  rd;
    bit [63:0] addr, wdata, rd_data;
    bit [7:0]  strb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start32, start64, mem_ready;
  logic [31:0] instruction;
  logic [63:0] rs1_data, rs2_data, mem_rdata;

  logic        busy32, done32, fault32, rd_we32, mem_req32, mem_we32;
  logic [1:0]  cause32;
  logic [4:0]  rd_addr32;
  logic [31:0] rd_data32, mem_addr32, mem_wdata32;
  logic [3:0]  mem_strb32;

  logic        busy64, done64, fault64, rd_we64, mem_req64, mem_we64;
  logic [1:0]  cause64;
  logic [4:0]  rd_addr64;
  logic [63:0] rd_data64, mem_addr64, mem_wdata64;
  logic [7:0]  mem_strb64;

  load_store_unit #(.XLEN(32), .REG_SELECT_LEN(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .instruction(instruction),
    .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]),
    .busy(busy32), .done(done32), .fault(fault32), .fault_cause(cause32),
    .rd_we(rd_we32), .rd_addr(rd_addr32), .rd_data(rd_data32),
    .mem_req(mem_req32), .mem_we(mem_we32), .mem_addr(mem_addr32),
    .mem_wdata(mem_wdata32), .mem_strb(mem_strb32),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata[31:0])
  );

  load_store_unit #(.XLEN(64), .REG_SELECT_LEN(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .busy(busy64), .done(done64), .fault(fault64), .fault_cause(cause64),
    .rd_we(rd_we64), .rd_addr(rd_addr64), .rd_data(rd_data64),
    .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64),
    .mem_wdata(mem_wdata64), .mem_strb(mem_strb64),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  bit   check_en = 1'b0;
  obs_t q32[$];
  obs_t q64[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural behaviour of one LOAD/STORE, computed with plain arithmetic.
  function automatic exp_t lsuModel(input int xlen, input bit [31:0] instr,
                                    input bit [63:0] rs1, input bit [63:0] rs2,
                                    input bit [63:0] rdata);
    exp_t      m;
    bit [63:0] xmask, ea, bmask, val;
    bit [11:0] i12;
    bit        is_load, is_store, legal;
    longint    imm;
    int        f3, size, off;
    m        = '0;
    xmask    = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
    is_load  = (instr[6:0] == 7'h03);
    is_store = (instr[6:0] == 7'h23);
    f3       = int'(instr[14:12]);
    size     = 1 << (f3 % 4);
    if (is_load)       legal = (f3 inside {0, 1, 2, 4, 5}) || (xlen == 64 && f3 inside {3, 6});
    else if (is_store) legal = (f3 <= 2) || (xlen == 64 && f3 == 3);
    else               legal = 1'b0;
    i12 = is_store ? {instr[31:25], instr[11:7]} : instr[31:20];
    imm = longint'(i12);
    if (i12[11]) imm = imm - 4096;
    ea    = (rs1 + imm) & xmask;
    off   = int'(ea % (xlen / 8));
    bmask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * size)) - 1;
    m.is_load = is_load;
    m.rd      = instr[11:7];
    m.fault   = !legal || (ea % size != 0);
    m.cause   = !legal ? 2'd2 : (m.fault ? 2'd1 : 2'd0);
    m.addr    = ea - off;
    m.strb    = 8'(((1 << size) - 1) << off);
    m.wdata   = ((rs2 & bmask) << (8 * off)) & xmask;
    val       = (rdata >> (8 * off)) & bmask;
    if (f3 < 4 && size < 8 && val[8*size-1]) val = val | ~bmask;
    m.rd_data = val & xmask;
    m.rd_we   = is_load && (m.rd != 0) && !m.fault;
    return m;
  endfunction

  function automatic obs_t cur32();
    obs_t o;
    o = '{busy: busy32, done: done32, fault: fault32, cause: cause32, rd_we: rd_we32,
          rd_addr: rd_addr32, rd_data: 64'(rd_data32), mem_req: mem_req32, mem_we: mem_we32,
          mem_addr: 64'(mem_addr32), mem_wdata: 64'(mem_wdata32), mem_strb: 8'(mem_strb32)};
    return o;
  endfunction

  function automatic obs_t cur64();
    obs_t o;
    o = '{busy: busy64, done: done64, fault: fault64, cause: cause64, rd_we: rd_we64,
          rd_addr: rd_addr64, rd_data: rd_data64, mem_req: mem_req64, mem_we: mem_we64,
          mem_addr: mem_addr64, mem_wdata: mem_wdata64, mem_strb: mem_strb64};
    return o;
  endfunction

  task automatic checkOutput(input string tag, input obs_t e, input obs_t a);
    check({tag, ".busy"}, 64'(a.busy), 64'(e.busy));
    check({tag, ".done"}, 64'(a.done), 64'(e.done));
    check({tag, ".mem_req"}, 64'(a.mem_req), 64'(e.mem_req));
    if (e.done) begin
      check({tag, ".fault"}, 64'(a.fault), 64'(e.fault));
      check({tag, ".fault_cause"}, 64'(a.cause), 64'(e.cause));
      check({tag, ".rd_we"}, 64'(a.rd_we), 64'(e.rd_we));
    end
    if (e.done && e.rd_we) begin
      check({tag, ".rd_addr"}, 64'(a.rd_addr), 64'(e.rd_addr));
      check({tag, ".rd_data"}, a.rd_data, e.rd_data);
    end
    if (e.mem_req) begin
      check({tag, ".mem_we"}, 64'(a.mem_we), 64'(e.mem_we));
      check({tag, ".mem_addr"}, a.mem_addr, e.mem_addr);
      check({tag, ".mem_wdata"}, a.mem_wdata, e.mem_wdata);
      check({tag, ".mem_strb"}, 64'(a.mem_strb), 64'(e.mem_strb));
    end
  endtask

  task automatic checkAllZero(input string tag, input obs_t a);
    check({tag, ".busy"}, 64'(a.busy), 0);
    check({tag, ".done"}, 64'(a.done), 0);
    check({tag, ".fault"}, 64'(a.fault), 0);
    check({tag, ".fault_cause"}, 64'(a.cause), 0);
    check({tag, ".rd_we"}, 64'(a.rd_we), 0);
    check({tag, ".rd_addr"}, 64'(a.rd_addr), 0);
    check({tag, ".rd_data"}, a.rd_data, 0);
    check({tag, ".mem_req"}, 64'(a.mem_req), 0);
    check({tag, ".mem_we"}, 64'(a.mem_we), 0);
    check({tag, ".mem_addr"}, a.mem_addr, 0);
    check({tag, ".mem_wdata"}, a.mem_wdata, 0);
    check({tag, ".mem_strb"}, 64'(a.mem_strb), 0);
  endtask

  // Single compare process: one expectation per DUT per cycle, idle when none queued.
  always @(negedge clk) begin
    obs_t e;
    if (check_en) begin
      e = '0;
      if (q32.size() != 0) e = q32.pop_front();
      checkOutput("dut32", e, cur32());
      e = '0;
      if (q64.size() != 0) e = q64.pop_front();
      checkOutput("dut64", e, cur64());
    end
  end

  function automatic void pushExp(input bit is64, input obs_t o);
    if (is64) q64.push_back(o);
    else      q32.push_back(o);
  endfunction

  // Entered and left just after a rising edge; the exit cycle may start the next op.
  task automatic applyStimulus(input bit is64, input bit [31:0] instr, input bit [63:0] rs1,
                               input bit [63:0] rs2, input bit [63:0] rdata, input int waits);
    exp_t m;
    obs_t o;
    int   n;
    bit   in_req;
    m = lsuModel(is64 ? 64 : 32, instr, rs1, rs2, rdata);
    pushExp(is64, '0);
    n = 0;
    if (m.fault) begin
      o = '0; o.busy = 1; o.done = 1; o.fault = 1; o.cause = m.cause;
      pushExp(is64, o); n = 1;
    end else begin
      o = '0; o.busy = 1; o.mem_req = 1; o.mem_we = !m.is_load;
      o.mem_addr = m.addr; o.mem_wdata = m.wdata; o.mem_strb = m.strb;
      for (int k = 0; k <= waits; k++) pushExp(is64, o);
      n = waits + 1;
      if (m.is_load) begin
        o = '0; o.busy = 1;
        pushExp(is64, o); n++;
      end
      o = '0; o.busy = 1; o.done = 1; o.rd_we = m.rd_we; o.rd_addr = m.rd; o.rd_data = m.rd_data;
      pushExp(is64, o); n++;
    end
    instruction = instr; rs1_data = rs1; rs2_data = rs2; mem_ready = 1'b0;
    if (is64) start64 = 1'b1; else start32 = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      in_req = !m.fault && (k <= waits + 1);
      if (is64) start64 = 1'($urandom_range(0, 1)); else start32 = 1'($urandom_range(0, 1));
      instruction = $urandom;
      rs1_data = {$urandom, $urandom};
      rs2_data = {$urandom, $urandom};
      mem_ready = in_req ? (k == waits + 1) : 1'($urandom_range(0, 1));
      mem_rdata = (in_req && k == waits + 1) ? rdata : {$urandom, $urandom};
    end
    @(posedge clk); #1;
    start32 = 1'b0; start64 = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t      m;
    bit        is64;
    bit [31:0] instr;
    bit [11:0] imm;
    bit [63:0] rs1;
    int        sel;

    rst_n = 1'b0; start32 = 1'b0; start64 = 1'b0; mem_ready = 1'b0;
    instruction = '0; rs1_data = '0; rs2_data = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset32", cur32());
    checkAllZero("reset64", cur64());
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 check_en = 1'b1;

    m = lsuModel(32, {12'hFFF, 5'd1, 3'b000, 5'd5, 7'h03}, 64'h100, 0, 64'h8000_0000);
    check("pin_lb_addr", m.addr, 64'hFC);
    check("pin_lb_strb", 64'(m.strb), 64'b1000);
    check("pin_lb_rd_data", m.rd_data, 64'hFFFF_FF80);
    applyStimulus(0, {12'hFFF, 5'd1, 3'b000, 5'd5, 7'h03}, 64'h100, 0, 64'h8000_0000, 0);

    m = lsuModel(32, {12'h000, 5'd2, 3'b101, 5'd6, 7'h03}, 64'h102, 0, 64'hBEEF_1234);
    check("pin_lhu_strb", 64'(m.strb), 64'b1100);
    check("pin_lhu_rd_data", m.rd_data, 64'h0000_BEEF);
    applyStimulus(0, {12'h000, 5'd2, 3'b101, 5'd6, 7'h03}, 64'h102, 0, 64'hBEEF_1234, 0);

    m = lsuModel(32, {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h23}, 64'h200, 64'h1234_56A5, 0);
    check("pin_sb_strb", 64'(m.strb), 64'b1000);
    check("pin_sb_wdata", m.wdata, 64'hA500_0000);
    check("pin_sb_rd_we", 64'(m.rd_we), 0);
    applyStimulus(0, {7'd0, 5'd2, 5'd1, 3'b000, 5'd3, 7'h23}, 64'h200, 64'h1234_56A5, 0, 0);

    m = lsuModel(32, {12'h000, 5'd1, 3'b010, 5'd7, 7'h03}, 64'h102, 0, 0);
    check("pin_lw_misaligned_cause", 64'(m.cause), 1);
    applyStimulus(0, {12'h000, 5'd1, 3'b010, 5'd7, 7'h03}, 64'h102, 0, 0, 0);
    m = lsuModel(32, {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'h33}, 64'h100, 0, 0);
    check("pin_op33_cause", 64'(m.cause), 2);
    applyStimulus(0, {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'h33}, 64'h100, 0, 0, 0);
    m = lsuModel(32, {12'h001, 5'd1, 3'b011, 5'd4, 7'h03}, 64'h100, 0, 0);
    check("pin_ld_on_rv32_cause", 64'(m.cause), 2);
    applyStimulus(0, {12'h001, 5'd1, 3'b011, 5'd4, 7'h03}, 64'h100, 0, 0, 0);

    applyStimulus(0, {12'h004, 5'd1, 3'b010, 5'd9, 7'h03}, 64'h100, 0, 64'hCAFE_F00D, 5);

    m = lsuModel(64, {12'h008, 5'd1, 3'b011, 5'd10, 7'h03}, 64'h1000, 0, 64'h0123_4567_89AB_CDEF);
    check("pin_ld_strb", 64'(m.strb), 64'hFF);
    applyStimulus(1, {12'h008, 5'd1, 3'b011, 5'd10, 7'h03}, 64'h1000, 0, 64'h0123_4567_89AB_CDEF, 0);
    m = lsuModel(64, {12'h004, 5'd1, 3'b110, 5'd11, 7'h03}, 64'h1000, 0, 64'h8000_0000_0000_0000);
    check("pin_lwu_rd_data", m.rd_data, 64'h0000_0000_8000_0000);
    applyStimulus(1, {12'h004, 5'd1, 3'b110, 5'd11, 7'h03}, 64'h1000, 0, 64'h8000_0000_0000_0000, 1);

    // Reset asserted in cycle 3 of a stalled load must clear everything by cycle 4.
    check_en = 1'b0;
    instruction = {12'h000, 5'd1, 3'b010, 5'd9, 7'h03};
    rs1_data = 64'h100; start32 = 1'b1;
    @(posedge clk); #1 start32 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_mid.mem_req_before", 64'(mem_req32), 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("reset_mid32", cur32());
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 check_en = 1'b1;

    for (int t = 0; t < 300; t++) begin
      is64 = 1'($urandom_range(0, 1));
      sel  = $urandom_range(0, 7);
      imm  = 12'($urandom);
      rs1  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        imm[2:0] = 3'b000;
        rs1[2:0] = 3'b000;
      end
      if (sel <= 3)
        instr = {imm, 5'($urandom), 3'($urandom), 5'($urandom), 7'h03};
      else if (sel <= 6)
        instr = {imm[11:5], 5'($urandom), 5'($urandom), 3'($urandom), imm[4:0], 7'h23};
      else
        instr = {imm, 5'($urandom), 3'($urandom), 5'($urandom), 7'($urandom)};
      applyStimulus(is64, instr, rs1, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised RISC-V load/store execution unit. Accepts one LOAD or STORE instruction plus its operand values, computes the effective address, drives a byte-strobed req/ready memory port, and for loads returns the sign- or zero-extended result on a register write-back port. Detects misaligned and illegal encodings and reports them as a fault instead of touching memory. Sits beside the ALU in the execute stage, sharing the register-file read/write ports via the core's issue logic.

## Interface
- `XLEN`, 32: datapath width; 32 or 64 only.
- `REG_SELECT_LEN`, 5: register index width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low (one clock; polarity and synchronicity fixed).
- `start` in 1: issue strobe; sampled only in IDLE.
- `instruction` in 32: instruction word, valid with `start`.
- `rs1_data`, `rs2_data` in XLEN: operand values, valid with `start`.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: with `done`, instruction aborted.
- `fault_cause` out 2: 0 none, 1 misaligned, 2 illegal.
- `rd_we` out 1, `rd_addr` out REG_SELECT_LEN, `rd_data` out XLEN: write-back, valid with `done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out XLEN, `mem_wdata` out XLEN, `mem_strb` out XLEN/8: memory request.
- `mem_ready` in 1, `mem_rdata` in XLEN: memory response.

## Operation
- States: IDLE, REQ, RESP, DONE (in package enum).
- IDLE + `start`: latch decode. opcode 0000011 = load, 0100011 = store, else illegal. Legal funct3, load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; XLEN=64 adds 011 LD, 110 LWU. Store: 000/001/010, plus 011 for XLEN=64. Other funct3 is illegal.
- Effective address = `rs1_data` + sign-extended imm (load imm[11:0]=instr[31:20]; store imm = {instr[31:25], instr[11:7]}), modulo 2^XLEN.
- Misaligned: address not a multiple of the access size. Illegal has priority over misaligned. Either fault: go to DONE with `fault`=1, no `mem_req`, `rd_we`=0.
- Otherwise go to REQ. `mem_addr` = effective address with the low log2(XLEN/8) bits cleared. `mem_strb` = size-wide mask shifted to the byte offset. `mem_wdata` = `rs2_data` low bytes shifted to the same lane.
- REQ: `mem_req`=1 and all `mem_*` held stable until `mem_ready`=1. On ready: a store goes to DONE; a load captures `mem_rdata` into RESP.
- RESP: extract the lane, sign- or zero-extend to XLEN, go to DONE.
- DONE: `done`=1 for one cycle, `rd_we`=1 only for a non-faulting load with rd≠0. Then IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset: every output 0 (no hi-Z anywhere), state IDLE. Reset in any state aborts at that edge and drops `mem_req` the next cycle; the memory side is reset in the same cycle.
- All outputs are registered.
- Load with ready in the first REQ cycle: `start` at cycle 0, `mem_req` cycles 1, RESP cycle 2, `done` cycle 3.
- Store: `done` cycle 2.
- Fault: `done`+`fault` cycle 1.
- Each wait cycle on `mem_ready` adds one cycle.
- Back-to-back: next `start` accepted in the cycle after `done`.

## Structure
- `lsu_pkg`: LsuState enum, opcode constants, funct3 constants, fault-cause constants.
- Sub-module `lsu_align`: combinational. Does strobe/wdata lane placement and rdata extraction/extension from (funct3, byte offset). It is instantiated twice: once for request formation, once for response.

## Test plan
- LB: rs1=0x100, imm=-1, `mem_rdata`=0x80000000 -> `mem_addr`=0xFC, `mem_strb`=1000, `rd_data`=0xFFFFFF80, `done` cycle 3.
- LHU: addr 0x102, rdata 0xBEEF1234 -> `mem_strb`=1100, `rd_data`=0x0000BEEF.
- SB: addr 0x203, rs2=0xA5 -> `mem_strb`=1000, `mem_wdata`=0xA5000000, `mem_we`=1, `rd_we`=0.
- LW at 0x102 -> `fault_cause`=1 in cycle 1, `mem_req` never asserted. Opcode 0x33 -> `fault_cause`=2.
- `mem_ready` held low 5 cycles -> `mem_*` stable, `done` at cycle 8. `rst_n` low at cycle 3 -> all outputs 0 at cycle 4.
- XLEN=64: LD at 0x1008 -> `mem_strb`=0xFF. LWU rdata upper word 0x80000000 -> `rd_data`=0x0000000080000000.
